// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder family.
// Holds the lookahead group width, the default operand width and the
// helper that turns an operand width into a group count.
package cla_pkg;

    localparam int GRP_W         = 4;
    localparam int DEFAULT_WIDTH = 28;

    // Number of 4-bit lookahead groups needed to cover an operand width.
    function automatic int num_groups(input int width);
        return width / GRP_W;
    endfunction

endpackage

// File: rtl/cla4_pg.sv
// 4-bit propagate/generate cell.
// Produces per-bit propagate (a|b) and generate (a&b) plus the group-level
// propagate and generate used by the group carry lookahead.
module cla4_pg (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p,
    output logic [3:0] g,
    output logic       p03,
    output logic       g03
);

    assign p = a | b;
    assign g = a & b;

    // Group generate: a carry leaves the group if any bit generates and
    // every bit above it propagates.
    assign g03 = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

    // Group propagate: an incoming carry passes only if every bit propagates.
    assign p03 = &p;

endmodule

// File: rtl/cla28_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 registers the operands together with per-bit and per-group P/G
// terms; stage 2 resolves group carries by lookahead, ripples the carry
// inside each group, forms the sum and registers sum/cout for the consumer.
module cla28_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GRP   = GRP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = num_groups(WIDTH);

    // ---------------------------------------------------------------
    // Combinational P/G generation on the incoming operands
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] p_comb;
    logic [WIDTH-1:0] g_comb;
    logic [NGRP-1:0]  p03_comb;
    logic [NGRP-1:0]  g03_comb;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_pg
            cla4_pg u_pg (
                .a   (a[gi*GRP +: GRP]),
                .b   (b[gi*GRP +: GRP]),
                .p   (p_comb[gi*GRP +: GRP]),
                .g   (g_comb[gi*GRP +: GRP]),
                .p03 (p03_comb[gi]),
                .g03 (g03_comb[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its contents move on
    // ---------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid_reg || out_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_reg;

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_cin_reg;
    logic [WIDTH-1:0] s1_p_reg;
    logic [WIDTH-1:0] s1_g_reg;
    logic [NGRP-1:0]  s1_p03_reg;
    logic [NGRP-1:0]  s1_g03_reg;

    // Capture operands and their P/G terms whenever stage 1 can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_cin_reg   <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s1_p03_reg   <= '0;
            s1_g03_reg   <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg   <= a;
                s1_b_reg   <= b;
                s1_cin_reg <= cin;
                s1_p_reg   <= p_comb;
                s1_g_reg   <= g_comb;
                s1_p03_reg <= p03_comb;
                s1_g03_reg <= g03_comb;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2 combinational: group lookahead, in-group carries, sum
    // ---------------------------------------------------------------
    logic [NGRP:0]    c_grp;
    logic [WIDTH-1:0] c_bit;
    logic             bit_c;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;

    // Group carries come from the lookahead chain; the per-bit carries inside
    // a group ripple from that group's lookahead carry-in.
    always_comb begin
        c_grp    = '0;
        c_bit    = '0;
        bit_c    = 1'b0;
        c_grp[0] = s1_cin_reg;
        for (int gidx = 0; gidx < NGRP; gidx++) begin
            c_grp[gidx+1] = s1_g03_reg[gidx] | (s1_p03_reg[gidx] & c_grp[gidx]);
            bit_c = c_grp[gidx];
            for (int k = 0; k < GRP; k++) begin
                c_bit[gidx*GRP + k] = bit_c;
                bit_c = s1_g_reg[gidx*GRP + k] | (s1_p_reg[gidx*GRP + k] & bit_c);
            end
        end
        // a^b is bit-for-bit the same as P&~G with P=a|b, G=a&b.
        sum_next  = (s1_a_reg ^ s1_b_reg) ^ c_bit;
        cout_next = c_grp[NGRP];
    end

    // ---------------------------------------------------------------
    // Stage 2 registers
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // Load the result whenever stage 2 is free or being drained; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_cla28_pipe_adder.sv
// Scoreboard bench for cla28_pipe_adder: accepted operand pairs push an
// expected result computed with plain integer addition; an output monitor
// pops and compares on every delivery.
module tb_cla28_pipe_adder;

    localparam int W = 28;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;

    cla28_pipe_adder #(.WIDTH(W), .GRP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   exp;
        int           acc_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];

    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;
    int  acc_count = 0;
    int  txn = 0;
    int  stale_count = 0;
    int  stream_stalls = 0;
    bit  lat_flag = 1'b0;
    bit  stream_phase = 1'b0;
    bit  prev_stall = 1'b0;
    logic [W:0] prev_out = '0;

    // Reference: unsigned addition one bit wider than the operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted operand pair with its expected result.
    always @(negedge clk) begin : acc_mon
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e.a       = a;
            e.b       = b;
            e.cin     = cin;
            e.exp     = ref_add(a, b, cin);
            e.acc_cyc = cyc;
            e.chk_lat = lat_flag;
            sb.push_back(e);
            acc_count++;
        end
        if (rst_n && stream_phase && !in_ready) stream_stalls++;
    end

    // Compare each delivered result; also verify outputs hold under stall.
    always @(negedge clk) begin : out_mon
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({out_valid, cout, sum}), 64'({1'b1, prev_out}));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    stale_count++;
                    check("unexpected_result_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    txn++;
                    $display("txn %0d: a=%07h b=%07h cin=%0d -> sum=%07h cout=%0d (lat %0d)",
                             txn, e.a, e.b, e.cin, sum, cout, cyc - e.acc_cyc);
                    check("result", 64'({cout, sum}), 64'(e.exp));
                    if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(2));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {cout, sum};
        end
    end

    // Present one operand pair and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        bit rnd_done;
        logic [W-1:0] xa;
        logic [W-1:0] xb;

        // Reset state
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_sum", 64'(sum), 64'(0));
        check("reset_cout", 64'(cout), 64'(0));
        rst_n = 1'b1;

        // Basic add with latency check
        lat_flag = 1'b1;
        send(28'h0000005, 28'h0000003, 1'b0);
        lat_flag = 1'b0;
        drain();

        // Full ripple cases and every group boundary
        send(28'hFFFFFFF, 28'h0000000, 1'b1);
        send(28'hFFFFFFF, 28'hFFFFFFF, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            xa = 28'hF << (4 * k);
            xb = 28'h1 << (4 * k);
            send(xa, xb, 1'b0);
        end
        drain();

        // Backpressure: 5 pairs offered while the consumer stalls for 4 cycles
        base = acc_count;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (c >= 2) begin
                        check("bp_in_ready_low", 64'(in_ready), 64'(0));
                        check("bp_accepted_two", 64'(acc_count - base), 64'(2));
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two pairs in flight
        send_rand();
        send_rand();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_sum_cout", 64'({cout, sum}), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = stale_count;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(stale_count - base), 64'(0));

        // Random traffic with random consumer backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) send_rand();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Full-rate streaming: one result per cycle, fixed latency
        stream_phase = 1'b1;
        lat_flag = 1'b1;
        for (int i = 0; i < 1000; i++) send_rand();
        stream_phase = 1'b0;
        lat_flag = 1'b0;
        drain();
        check("stream_in_ready_drops", 64'(stream_stalls), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cla28_pipe_adder.md
CLA28_PIPE_ADDER -- requirements
Module: cla28_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, 28, operand width; legal values are multiples of 4 only.
REQ-002 SHALL have parameter GRP, 4, bits per lookahead group; fixed at 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL accept an operand pair on a cycle where in_valid and in_ready are both high, and on no other cycle.
REQ-015 SHALL deliver a result on a cycle where out_valid and out_ready are both high; sum and cout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 Stage S1 SHALL register a, b, cin, per-bit P=a|b, G=a&b, and per-group P03/G03 for WIDTH/4 groups.
REQ-017 Group terms SHALL be G03=G3|P3G2|P3P2G1|P3P2P1G0 and P03=P3&P2&P1&P0.
REQ-018 Stage S2 SHALL compute group carries by lookahead: c[g+1]=G03[g]|(P03[g]&c[g]), c[0]=cin.
REQ-019 Stage S2 SHALL then derive in-group bit carries, set sum[i]=(P&~G)[i]^c[i], and register sum and cout.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid when no stall is present.
REQ-021 Throughput SHALL be one result per cycle while out_ready=1.
REQ-022 Stage advance: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
REQ-023 in_ready SHALL equal s1_adv and SHALL NOT depend combinationally on in_valid.
REQ-024 SHALL not drop, duplicate, or reorder results; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-025 Simultaneous acceptance and delivery in one cycle SHALL keep the pipeline full with no bubble inserted.
REQ-026 Arithmetic SHALL be unsigned; overflow is reported only through cout; the all-ones+0+cin=1 case SHALL ripple through all groups correctly.

Reset
REQ-027 rst_n=0 SHALL immediately clear s1_valid, s2_valid, out_valid, sum, cout, and all pipeline data registers to 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operands, with no result emitted after release.
REQ-029 While rst_n=0, in_ready SHALL be 1 (both stages empty); the first acceptance is allowed on the first clock edge after release.

Structure
REQ-030 A shared package cla_pkg SHALL hold the group width (4), the default width (28), and the group-count function WIDTH/4.
REQ-031 The per-group P/G generator SHALL be a sub-module cla4_pg (inputs a[3:0], b[3:0]; outputs P, G, P03, G03), instantiated WIDTH/4 times.
REQ-032 Lookahead carry, sum, and handshake logic SHALL reside in cla28_pipe_adder.

Verification
REQ-033 Basic add: a=0x0000005, b=0x0000003, cin=0 -> sum=0x0000008, cout=0, out_valid exactly 2 cycles after acceptance.
REQ-034 Full ripple: a=0xFFFFFFF, b=0x0000000, cin=1 -> sum=0x0000000, cout=1; a=0xFFFFFFF, b=0xFFFFFFF, cin=1 -> sum=0xFFFFFFF, cout=1.
REQ-035 Backpressure: stream 5 pairs with out_ready=0 for 4 cycles -> in_ready drops after 2 acceptances, sum holds stable, all 5 results are later delivered in order and match a+b+cin.
REQ-036 Streaming: random pairs with in_valid=out_ready=1 for 1000 cycles -> one result per cycle, each result equals (a+b+cin) mod 2^28 with the correct cout.
REQ-037 Reset mid-flight: accept 2 pairs, assert rst_n=0 for 1 cycle -> out_valid=0 immediately and no stale result appears after release.
REQ-038 Group boundary: a=0x000000F, b=0x0000001 -> sum=0x0000010, exercising the group0-to-group1 carry; repeat at every 4-bit boundary up to bit 24.
